wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and general-purpose register file for the pipelined CPU. Consumes the MEM/WB pipeline register outputs, selects the write-back value (ALU result or memory load data), and commits it to a 32-entry register file on the clock edge. Provides the two combinational read ports used by the ID stage, with write-through bypass so an ID read in the same cycle as a WB write sees the new value.

## Interface
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width; depth = 2**ADDR_W (32 entries)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- MEM_WB_ALU_Result  in  DATA_W  ALU result from MEM/WB register
- MemReadData  in  DATA_W  load data from MEM/WB register
- MEM_WB_Addr  in  ADDR_W  destination register number
- WB  in  2  write-back control: WB[1] = RegWrite, WB[0] = MemtoReg
- ReadReg1  in  ADDR_W  ID read address, port 1 (rs)
- ReadReg2  in  ADDR_W  ID read address, port 2 (rt)
- ReadData1  out  DATA_W  port 1 read data (combinational)
- ReadData2  out  DATA_W  port 2 read data (combinational)
- WriteData  out  DATA_W  selected write-back value (combinational; for EX forwarding)
- RegWrite_out  out  1  effective write enable (for forwarding/hazard logic)

## Operation
- Write-back select: WriteData = WB[0] ? MemReadData : MEM_WB_ALU_Result.
- Effective write enable: RegWrite_out = WB[1] & (MEM_WB_Addr != 0) & ~rst.
- Commit: at posedge clk with RegWrite_out = 1, regs[MEM_WB_Addr] <= WriteData. No other entry changes.
- Register 0: reads always return 0; writes to 0 are discarded (RegWrite_out = 0).
- Read ports, each independently: if ReadRegN == 0 -> 0; else if RegWrite_out & (ReadRegN == MEM_WB_Addr) -> WriteData (bypass); else regs[ReadRegN].
- Both ports may address the same register; both return the same value.
- Reset: at posedge clk with rst = 1, all 32 entries cleared to 0; any concurrent write is dropped (reset wins).
- While rst = 1: ReadData1 = ReadData2 = 0, WriteData = 0, RegWrite_out = 0.
- WB = 2'b01 (MemtoReg without RegWrite): no write, WriteData still shows MemReadData, no bypass.
- Undriven/X inputs while WB[1] = 0 must not alter register contents.

## Timing
- Write latency: value presented in cycle N is stored at the posedge ending cycle N; a non-bypassed read returns it from cycle N+1.
- Bypass latency: 0 cycles; same-cycle ID read of MEM_WB_Addr returns WriteData combinationally.
- Read path: purely combinational from ReadRegN, MEM_WB_Addr, WB, data inputs and stored array.
- Reset: takes effect at the first posedge with rst = 1; the array reads 0 from the following cycle; outputs are forced 0 combinationally while rst is asserted.
- Reset deasserted: first write can commit at the first posedge with rst = 0.
- Back-to-back writes to the same register: last write wins; each cycle's read sees that cycle's bypass value.

## Test plan
- Reset then read all: rst = 1 one cycle, then ReadReg1/2 sweep 0..31 -> every read returns 0x00000000; RegWrite_out = 0 during reset.
- ALU write then read: WB = 2'b10, Addr = 5, ALU_Result = 0x12345678, one clock; next cycle WB = 0, ReadReg1 = 5 -> ReadData1 = 0x12345678; MemReadData ignored.
- Load write with bypass: WB = 2'b11, Addr = 9, MemReadData = 0xDEADBEEF, ReadReg1 = ReadReg2 = 9 in same cycle -> both ports = 0xDEADBEEF before the edge, and again after it with WB = 0.
- Register 0 protection: WB = 2'b10, Addr = 0, ALU_Result = 0xFFFFFFFF -> RegWrite_out = 0, ReadReg1 = 0 returns 0 in same and next cycle.
- No-write control: WB = 2'b01, Addr = 3, MemReadData = 0xAAAA5555 -> WriteData = 0xAAAA5555, RegWrite_out = 0, regs[3] unchanged (still prior value 0).
- Reset mid-operation: write 0x11 to reg 7, then assert rst in the same cycle as WB = 2'b10, Addr = 7, ALU_Result = 0x22 -> after edge, reg 7 reads 0 (not 0x22, not 0x11).

Source files
------------

// File: rtl/wb_regfile_if.sv
// Write-back / register-file port bundle between the MEM/WB stage, the ID stage and forwarding logic.
// Signal names follow the CPU datapath names used by the neighbouring pipeline stages.
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [DATA_W-1:0] MEM_WB_ALU_Result;
  logic [DATA_W-1:0] MemReadData;
  logic [ADDR_W-1:0] MEM_WB_Addr;
  logic [1:0]        WB;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite_out;

  // Pipeline side: drives the MEM/WB fields and ID read addresses.
  modport master (
    output MEM_WB_ALU_Result, MemReadData, MEM_WB_Addr, WB, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2, WriteData, RegWrite_out
  );

  // Register-file side.
  modport slave (
    input  MEM_WB_ALU_Result, MemReadData, MEM_WB_Addr, WB, ReadReg1, ReadReg2,
    output ReadData1, ReadData2, WriteData, RegWrite_out
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back select and 32-entry general-purpose register file with two
// combinational read ports and same-cycle write-through bypass.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] wdata_c;
  logic              we_c;
  logic [DATA_W-1:0] rd1_c;
  logic [DATA_W-1:0] rd2_c;

  // Write-back value and effective enable; both forced low while in reset.
  always_comb begin
    wdata_c = '0;
    we_c    = 1'b0;
    if (!rst) begin
      wdata_c = bus.WB[0] ? bus.MemReadData : bus.MEM_WB_ALU_Result;
      we_c    = bus.WB[1] & (bus.MEM_WB_Addr != '0);
    end
  end

  // Read port 1: r0 is hardwired zero, bypass beats the stored entry.
  always_comb begin
    rd1_c = '0;
    if (!rst && (bus.ReadReg1 != '0)) begin
      if (we_c && (bus.ReadReg1 == bus.MEM_WB_Addr)) rd1_c = wdata_c;
      else                                           rd1_c = regs[bus.ReadReg1];
    end
  end

  // Read port 2: identical to port 1.
  always_comb begin
    rd2_c = '0;
    if (!rst && (bus.ReadReg2 != '0)) begin
      if (we_c && (bus.ReadReg2 == bus.MEM_WB_Addr)) rd2_c = wdata_c;
      else                                           rd2_c = regs[bus.ReadReg2];
    end
  end

  assign bus.ReadData1    = rd1_c;
  assign bus.ReadData2    = rd2_c;
  assign bus.WriteData    = wdata_c;
  assign bus.RegWrite_out = we_c;

  // Reset clears every entry and drops any concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (we_c) begin
      regs[bus.MEM_WB_Addr] <= wdata_c;
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares whenever a checked cycle is flagged.
module tb_wb_regfile;
  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] wd;
    logic        we;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_valid = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after posedge and queue its expected outputs.
  task automatic step(input logic r, input logic [1:0] wb, input logic [4:0] addr,
                      input logic [31:0] alu, input logic [31:0] mem,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic [31:0] ew, input logic ewe, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst                   = r;
    bus.WB                = wb;
    bus.MEM_WB_Addr       = addr;
    bus.MEM_WB_ALU_Result = alu;
    bus.MemReadData       = mem;
    bus.ReadReg1          = r1;
    bus.ReadReg2          = r2;
    e.name = name; e.rd1 = e1; e.rd2 = e2; e.wd = ew; e.we = ewe;
    exp_q.push_back(e);
    chk_valid = 1'b1;
  endtask

  task automatic cmp(input string name, input string field, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", name, field, got, want);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (chk_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp(e.name, "ReadData1", bus.ReadData1, e.rd1);
        cmp(e.name, "ReadData2", bus.ReadData2, e.rd2);
        cmp(e.name, "WriteData", bus.WriteData, e.wd);
        cmp(e.name, "RegWrite_out", {31'd0, bus.RegWrite_out}, {31'd0, e.we});
      end
    end
  end

  initial begin
    bus.WB = 2'b00; bus.MEM_WB_Addr = '0; bus.MEM_WB_ALU_Result = '0;
    bus.MemReadData = '0; bus.ReadReg1 = '0; bus.ReadReg2 = '0;

    // Reset with a write pending: everything forced to zero.
    step(1, 2'b10, 5'd4, 32'h55, 32'h0, 5'd4, 5'd1, 0, 0, 0, 0, "reset");
    for (int i = 0; i < 32; i++)
      step(0, 2'b00, 5'd0, 32'h0, 32'h0, 5'(i), 5'(31 - i), 0, 0, 0, 0, "sweep");

    // ALU write, then read back.
    step(0, 2'b10, 5'd5, 32'h12345678, 32'hCAFEF00D, 5'd1, 5'd2, 0, 0, 32'h12345678, 1, "alu_wr");
    step(0, 2'b00, 5'd5, 32'h0, 32'h0, 5'd5, 5'd5, 32'h12345678, 32'h12345678, 0, 0, "alu_rd");

    // Load write with same-cycle bypass on both ports.
    step(0, 2'b11, 5'd9, 32'h1111, 32'hDEADBEEF, 5'd9, 5'd9, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1, "ld_byp");
    step(0, 2'b00, 5'd9, 32'h0, 32'h0, 5'd9, 5'd9, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, "ld_rd");

    // Register 0 protection.
    step(0, 2'b10, 5'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd5, 0, 32'h12345678, 32'hFFFFFFFF, 0, "r0_wr");
    step(0, 2'b00, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 0, 0, 0, "r0_rd");

    // MemtoReg without RegWrite: no write, no bypass.
    step(0, 2'b01, 5'd3, 32'h3333, 32'hAAAA5555, 5'd3, 5'd9, 0, 32'hDEADBEEF, 32'hAAAA5555, 0, "nowr");
    step(0, 2'b00, 5'd3, 32'h0, 32'h0, 5'd3, 5'd3, 0, 0, 0, 0, "nowr_rd");

    // Reset mid-operation beats a concurrent write.
    step(0, 2'b10, 5'd7, 32'h11, 32'h0, 5'd7, 5'd5, 32'h11, 32'h12345678, 32'h11, 1, "r7_wr");
    step(0, 2'b00, 5'd7, 32'h0, 32'h0, 5'd7, 5'd7, 32'h11, 32'h11, 0, 0, "r7_rd");
    step(1, 2'b10, 5'd7, 32'h22, 32'h0, 5'd7, 5'd9, 0, 0, 0, 0, "rst_mid");
    step(0, 2'b00, 5'd7, 32'h0, 32'h0, 5'd7, 5'd9, 0, 0, 0, 0, "post_rst");
    step(0, 2'b00, 5'd5, 32'h0, 32'h0, 5'd5, 5'd3, 0, 0, 0, 0, "post_rst2");

    // Back-to-back writes to one register: last write wins.
    step(0, 2'b10, 5'd12, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd12, 5'd12, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1, "b2b_1");
    step(0, 2'b11, 5'd12, 32'h0BAD0BAD, 32'hB0B0B0B0, 5'd12, 5'd0, 32'hB0B0B0B0, 0, 32'hB0B0B0B0, 1, "b2b_2");
    step(0, 2'b00, 5'd12, 32'h0, 32'h0, 5'd12, 5'd12, 32'hB0B0B0B0, 32'hB0B0B0B0, 0, 0, "b2b_rd");

    // First write commits on the first edge after reset deasserts.
    step(1, 2'b00, 5'd0, 32'h0, 32'h0, 5'd12, 5'd20, 0, 0, 0, 0, "rst2");
    step(0, 2'b10, 5'd20, 32'h77, 32'h0, 5'd20, 5'd12, 32'h77, 0, 32'h77, 1, "first_wr");
    step(0, 2'b00, 5'd0, 32'h0, 32'h0, 5'd20, 5'd31, 32'h77, 0, 0, 0, "first_rd");

    @(posedge clk);
    #1;
    chk_valid = 1'b0;
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
